endpoint_ctrl: RTL and testbench
================================

ENDPOINT_CTRL -- requirements
Module: endpoint_ctrl

Interface
REQ-001 Parameter DEV_ADDR, default 7'd0, the only USB device address accepted.
REQ-002 Parameter EP_NUM, default 4'd0, the only endpoint number accepted.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 token_in  input  24  token packet: [7:0] PID, [14:8] address, [18:15] endpoint, [23:19] CRC5.
REQ-006 token_in_strb  input  1  one-cycle strobe: token_in valid.
REQ-007 data_in  input  8  received data-packet payload byte.
REQ-008 data_in_strb  input  1  data_in valid this cycle.
REQ-009 data_in_end  input  1  one-cycle strobe: data packet completed.
REQ-010 data_in_fail  input  1  data packet corrupt (CRC/PHY error).
REQ-011 pid  input  8  PID byte of the current data packet.
REQ-012 data_o  output  8  handshake byte to the transmitter.
REQ-013 data_o_start_stop  output  1  start marker (registered) and stop marker (combinational) of the transmit packet.
REQ-014 data_o_strb  input  1  transmitter has consumed the packet and requests the stop.
REQ-015 data_o_fail  input  1  transmitter aborted.

Function
REQ-016 States: IDLE, RX_DATA, TX_START, TX_WAIT; IDLE after reset.
REQ-017 A token is valid when token_in[3:0] == ~token_in[7:4], address == DEV_ADDR and endpoint == EP_NUM; invalid tokens are ignored; CRC5 is not checked.
REQ-018 Valid SETUP (0x2D) or OUT (0xE1) token sampled with token_in_strb: clear byte counter, go to RX_DATA.
REQ-019 Valid IN (0x69) token: load NAK (0x5A), go to TX_START on the next edge.
REQ-020 token_in_strb in any state except TX_START/TX_WAIT restarts token decoding; in TX_START/TX_WAIT it is ignored.
REQ-021 RX_DATA: each edge with data_in_strb increments a 7-bit byte counter (saturates at 127); data_in bytes are not stored.
REQ-022 RX_DATA with data_in_end: SETUP requires count == 8; OUT requires count <= 64; if met, load ACK (0xD2) and go to TX_START, else go to IDLE. A byte strobed on the same edge as data_in_end is counted first.
REQ-023 data_in_fail in RX_DATA: go to IDLE, no handshake; data_in_fail has priority over data_in_end.
REQ-024 data_in_strb / data_in_end outside RX_DATA: ignored.
REQ-025 TX_START (exactly one cycle): data_o = handshake byte, data_o_start_stop = 1 (registered); next state TX_WAIT. ACK therefore appears on the first edge after the edge sampling data_in_end.
REQ-026 TX_WAIT: data_o = 0; data_o_start_stop = data_o_strb (combinational, same cycle); on an edge with data_o_strb go to IDLE.
REQ-027 data_o_fail in TX_WAIT: go to IDLE; data_o_start_stop stays 0 that cycle; data_o_fail has priority over data_o_strb.
REQ-028 Outside TX_START and TX_WAIT: data_o = 0, data_o_start_stop = 0.
REQ-029 Back-to-back transactions are supported: a new token is accepted on the first cycle after TX_WAIT exits.

Reset
REQ-030 nrst low: immediately state = IDLE, counter = 0, handshake register = 0, data_o = 0, data_o_start_stop = 0, including mid-transaction.
REQ-031 The first edge after nrst release can accept a token.

Configuration
REQ-032 Macro ENDPOINT_CTRL_PID_CHECK_EN: when defined, data_in_end produces an ACK only if pid is DATA0 (0xC3) or DATA1 (0x4B), otherwise go to IDLE silently; when undefined, pid is ignored.

Verification
REQ-033 Token 0xF8002D strobed one cycle, 8 strobed bytes 0x05, data_in_end -> data_o 0 throughout; the cycle after data_in_end: data_o = 0xD2, start_stop = 1; the next cycles: 0/0; data_o_strb raised -> start_stop = 1 in the same cycle, data_o = 0; the following cycle: 0/0.
REQ-034 The REQ-033 sequence repeated 5 times back-to-back -> identical response every time.
REQ-035 SETUP token, 8 bytes, data_in_fail instead of data_in_end -> no start_stop pulse; the next SETUP sequence is ACKed normally.
REQ-036 SETUP token with address 5, 8 bytes, data_in_end -> no output activity.
REQ-037 SETUP token with 7 bytes -> no handshake; IN token 0xF80069 -> data_o = 0x5A with start_stop = 1 one cycle after the strobe.
REQ-038 ACK issued, data_o_fail in TX_WAIT -> start_stop stays 0; IDLE on the next cycle; nrst pulsed in RX_DATA -> outputs 0, next transaction ACKed.

Source files
------------

// File: rtl/endpoint_ctrl.sv
// USB endpoint handshake controller. It decodes tokens, counts the payload bytes of a data
// packet, and answers with an ACK or NAK handshake. Define ENDPOINT_CTRL_PID_CHECK_EN to
// ACK only DATA0/DATA1 packets.
module endpoint_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'd0,
    parameter logic [3:0] EP_NUM   = 4'd0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [23:0] token_in,
    input  logic        token_in_strb,
    input  logic [7:0]  data_in,
    input  logic        data_in_strb,
    input  logic        data_in_end,
    input  logic        data_in_fail,
    input  logic [7:0]  pid,
    output logic [7:0]  data_o,
    output logic        data_o_start_stop,
    input  logic        data_o_strb,
    input  logic        data_o_fail
);
    // state    | meaning
    // IDLE     | waiting for a token addressed to this endpoint
    // RX_DATA  | counting payload bytes of a SETUP/OUT data packet
    // TX_START | one cycle: handshake byte on data_o, start marker high
    // TX_WAIT  | waiting for the transmitter to request the stop marker
    typedef enum logic [1:0] {IDLE, RX_DATA, TX_START, TX_WAIT} state_t;

    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    state_t     state, state_nxt;
    logic [6:0] byte_cnt, byte_cnt_nxt;
    logic [7:0] hs_byte, hs_byte_nxt;
    logic       is_setup, is_setup_nxt;

    logic       tok_ok;
    logic [6:0] cnt_now;
    logic       len_ok;
    logic       pid_ok;
    logic       unused_bits;

    assign tok_ok = token_in_strb
                  && (token_in[3:0] == ~token_in[7:4])
                  && (token_in[14:8] == DEV_ADDR)
                  && (token_in[18:15] == EP_NUM);

    // A byte strobed together with data_in_end belongs to the packet.
    always_comb begin
        cnt_now = byte_cnt;
        if (data_in_strb && byte_cnt != 7'd127)
            cnt_now = byte_cnt + 7'd1;
    end

    assign len_ok = is_setup ? (cnt_now == 7'd8) : (cnt_now <= 7'd64);

`ifdef ENDPOINT_CTRL_PID_CHECK_EN
    assign pid_ok = (pid == 8'hC3) || (pid == 8'h4B);
`else
    assign pid_ok = 1'b1;
`endif

    // Payload and CRC5 are never inspected.
    assign unused_bits = ^{data_in, token_in[23:19], pid};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            byte_cnt <= 7'd0;
            hs_byte  <= 8'h00;
            is_setup <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            hs_byte  <= hs_byte_nxt;
            is_setup <= is_setup_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        byte_cnt_nxt      = byte_cnt;
        hs_byte_nxt       = hs_byte;
        is_setup_nxt      = is_setup;
        data_o            = 8'h00;
        data_o_start_stop = 1'b0;

        case (state)
            IDLE, RX_DATA: begin
                if (state == RX_DATA) begin
                    byte_cnt_nxt = cnt_now;
                    if (data_in_fail)
                        state_nxt = IDLE;
                    else if (data_in_end) begin
                        if (len_ok && pid_ok) begin
                            hs_byte_nxt = PID_ACK;
                            state_nxt   = TX_START;
                        end else
                            state_nxt = IDLE;
                    end
                end
                // A fresh valid token overrides whatever the data path decided.
                if (tok_ok) begin
                    if (token_in[7:0] == PID_SETUP || token_in[7:0] == PID_OUT) begin
                        byte_cnt_nxt = 7'd0;
                        is_setup_nxt = (token_in[7:0] == PID_SETUP);
                        state_nxt    = RX_DATA;
                    end else if (token_in[7:0] == PID_IN) begin
                        hs_byte_nxt = PID_NAK;
                        state_nxt   = TX_START;
                    end
                end
            end
            TX_START: begin
                data_o            = hs_byte;
                data_o_start_stop = 1'b1;
                state_nxt         = TX_WAIT;
            end
            TX_WAIT: begin
                if (data_o_fail)
                    state_nxt = IDLE;
                else if (data_o_strb) begin
                    data_o_start_stop = 1'b1;
                    state_nxt         = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_endpoint_ctrl.sv
// Directed bench for endpoint_ctrl: SETUP/OUT/IN transactions, error paths and reset.
module tb_endpoint_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [23:0] token_in = '0;
    logic        token_in_strb = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_in_strb = 1'b0;
    logic        data_in_end = 1'b0;
    logic        data_in_fail = 1'b0;
    logic [7:0]  pid = 8'hC3;
    logic [7:0]  data_o;
    logic        data_o_start_stop;
    logic        data_o_strb = 1'b0;
    logic        data_o_fail = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [23:0] TOK_SETUP  = 24'hF8002D;
    localparam logic [23:0] TOK_OUT    = 24'hF800E1;
    localparam logic [23:0] TOK_IN     = 24'hF80069;
    localparam logic [23:0] TOK_SETUP5 = 24'hF8052D;

    endpoint_ctrl dut (
        .clk(clk), .nrst(nrst), .token_in(token_in), .token_in_strb(token_in_strb),
        .data_in(data_in), .data_in_strb(data_in_strb), .data_in_end(data_in_end),
        .data_in_fail(data_in_fail), .pid(pid), .data_o(data_o),
        .data_o_start_stop(data_o_start_stop), .data_o_strb(data_o_strb),
        .data_o_fail(data_o_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got ss=%b data=%02h, wanted ss=%b data=%02h",
                     tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Inputs are set just after an edge; outputs are checked 2 time units later.
    task automatic look(input string tag, input logic [8:0] exp);
        #2;
        chk(tag, {data_o_start_stop, data_o}, exp);
    endtask

    // kind: 0 = data_in_end, 1 = data_in_fail
    task automatic run_txn(input logic [23:0] tok, input int nbytes, input bit kind,
                           input bit ack);
        token_in = tok; token_in_strb = 1'b1;
        look("tok", 9'h000);
        cyc();
        token_in_strb = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            data_in = 8'h05; data_in_strb = 1'b1;
            look("rx_byte", 9'h000);
            cyc();
        end
        data_in_strb = 1'b0;
        if (kind) data_in_fail = 1'b1; else data_in_end = 1'b1;
        look("rx_end", 9'h000);
        cyc();
        data_in_end = 1'b0; data_in_fail = 1'b0;
        look("hs_start", ack ? 9'h1D2 : 9'h000);
        cyc();
        look("tx_wait", 9'h000);
        cyc();
        data_o_strb = 1'b1;
        look("tx_stop", ack ? 9'h100 : 9'h000);
        cyc();
        data_o_strb = 1'b0;
        look("after_stop", 9'h000);
    endtask

    initial begin
        #3;
        chk("reset", {data_o_start_stop, data_o}, 9'h000);
        #10 nrst = 1'b1;
        cyc();

        run_txn(TOK_SETUP, 8, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) run_txn(TOK_SETUP, 8, 1'b0, 1'b1);

        run_txn(TOK_SETUP, 8, 1'b1, 1'b0);
        run_txn(TOK_SETUP, 8, 1'b0, 1'b1);

        run_txn(TOK_SETUP5, 8, 1'b0, 1'b0);

        run_txn(TOK_SETUP, 7, 1'b0, 1'b0);
        run_txn(TOK_SETUP, 9, 1'b0, 1'b0);

        // IN answers with NAK one cycle after its strobe.
        token_in = TOK_IN; token_in_strb = 1'b1;
        look("in_tok", 9'h000);
        cyc();
        token_in_strb = 1'b0;
        look("in_nak", 9'h15A);
        cyc();
        data_o_strb = 1'b1;
        look("in_stop", 9'h100);
        cyc();
        data_o_strb = 1'b0;
        look("in_idle", 9'h000);

        run_txn(TOK_OUT, 64, 1'b0, 1'b1);
        run_txn(TOK_OUT, 65, 1'b0, 1'b0);
        run_txn(TOK_OUT, 0, 1'b0, 1'b1);

        // The last byte strobed on the data_in_end edge counts toward the eight.
        token_in = TOK_SETUP; token_in_strb = 1'b1;
        cyc();
        token_in_strb = 1'b0;
        for (int i = 0; i < 7; i++) begin data_in_strb = 1'b1; cyc(); end
        data_in_end = 1'b1;
        cyc();
        data_in_strb = 1'b0; data_in_end = 1'b0;
        look("same_edge_ack", 9'h1D2);
        cyc();
        // data_o_fail beats data_o_strb in TX_WAIT.
        data_o_fail = 1'b1; data_o_strb = 1'b1;
        look("tx_fail", 9'h000);
        cyc();
        data_o_fail = 1'b0;
        look("fail_idle", 9'h000);
        cyc();
        data_o_strb = 1'b0;

        // A token strobe in TX_START must not restart decoding.
        token_in = TOK_IN; token_in_strb = 1'b1;
        cyc();
        token_in = TOK_SETUP;
        look("tok_in_txs", 9'h15A);
        cyc();
        token_in_strb = 1'b0;
        look("tok_in_txw", 9'h000);
        data_o_strb = 1'b1;
        look("tok_ign_stop", 9'h100);
        cyc();
        data_o_strb = 1'b0;

        // Reset mid-RX_DATA, then a normal transaction.
        token_in = TOK_SETUP; token_in_strb = 1'b1;
        cyc();
        token_in_strb = 1'b0;
        data_in_strb = 1'b1;
        cyc(); cyc(); cyc();
        data_in_strb = 1'b0;
        nrst = 1'b0;
        look("rst_rx", 9'h000);
        cyc();
        nrst = 1'b1;
        run_txn(TOK_SETUP, 8, 1'b0, 1'b1);

        // Asynchronous reset clears TX_START outputs without a clock edge.
        token_in = TOK_IN; token_in_strb = 1'b1;
        cyc();
        token_in_strb = 1'b0;
        look("pre_rst_tx", 9'h15A);
        nrst = 1'b0;
        look("rst_tx", 9'h000);
        cyc();
        nrst = 1'b1;
        run_txn(TOK_SETUP, 8, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
